timer_ctrl: RTL

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl_pkg.sv | 24 ++
 rtl/timer_ctrl_tick_prescaler.sv | 37 +++
 rtl/timer_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the timer_ctrl block: FSM state encoding, default
// sizing constants and a small helper used to size the prescaler counter.
// Optional prescaler is enabled by defining TIMER_CTRL_PRESCALE_EN.
package timer_ctrl_pkg;

    // Default counter/period width in bits.
    localparam int TIMER_WIDTH_DEFAULT = 4;

    // Default number of clock cycles per count step when the prescaler is built in.
    localparam int PRESCALE_DEFAULT = 4;

    // Controller states; the encoding is fixed so software/debug views stay stable.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..p-1, never less than one bit.
    function automatic int prescale_cnt_width(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/timer_ctrl_tick_prescaler.sv
// tick_prescaler: divides the clock down to a one-cycle advance strobe every
// PRESCALE cycles. Only built when TIMER_CTRL_PRESCALE_EN is defined; the
// plain build advances the timer every cycle and has no need for it.
`ifdef TIMER_CTRL_PRESCALE_EN
module tick_prescaler
    import timer_ctrl_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic strobe
);

    localparam int              CW   = prescale_cnt_width(PRESCALE);
    localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;

    // The strobe is the last phase of the divide-by-PRESCALE cycle, so the
    // first strobe lands on the PRESCALE-th cycle after a clear.
    assign strobe = (cnt_q == LAST);

    // Phase counter: restarts on clear, wraps after the strobe phase.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (strobe) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule
`endif

// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable one-shot / periodic timer.
// A start in IDLE latches period and auto_reload and runs the count from 0 up
// to the latched period. At the terminal count a one-cycle tick is issued;
// periodic runs wrap to 0, one-shot runs pass through DONE (one-cycle done
// pulse) back to IDLE. stop aborts a run without a done pulse.
// Define TIMER_CTRL_PRESCALE_EN to advance the count only every PRESCALE
// cycles instead of every cycle.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH    = TIMER_WIDTH_DEFAULT,
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] period,
    input  logic             auto_reload,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic [WIDTH-1:0] count_out
);

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] period_q;
    logic             reload_q;
    logic             busy_q;
    logic             done_q;

    logic             advance;
    logic             at_terminal;
    logic             start_ok;

    // A start is only honoured in IDLE, and a simultaneous stop vetoes it.
    assign start_ok    = (state_q == IDLE) && start && !stop;

    // Count has reached the latched terminal value while running.
    assign at_terminal = (state_q == RUN) && (count_q == period_q);

    // An abort in the same cycle swallows the terminal tick.
    assign tick        = at_terminal && advance && !stop;

`ifdef TIMER_CTRL_PRESCALE_EN
    logic presc_clear;

    // Hold the prescaler at phase 0 outside RUN (which also covers the
    // accepted-start cycle), on abort, and on a periodic wrap so each
    // period starts on a fresh prescale boundary.
    assign presc_clear = (state_q != RUN) || stop || (tick && reload_q);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .clear  (presc_clear),
        .strobe (advance)
    );
`else
    // Without the prescaler every running cycle is a count step.
    assign advance = 1'b1;
`endif

    // Controller FSM with the counter, latched configuration and registered
    // busy/done outputs all updated together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            period_q <= '0;
            reload_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    count_q <= '0;
                    if (start_ok) begin
                        period_q <= period;
                        reload_q <= auto_reload;
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= IDLE;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (advance) begin
                        if (count_q == period_q) begin
                            if (reload_q) begin
                                count_q <= '0;
                            end else begin
                                // Count holds at the terminal value through DONE.
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            count_q <= count_q + WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    count_q <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign count_out = count_q;

endmodule
